uart_rx: RTL and testbench

Oversampling UART receiver for the pipeline's serial debug/load port. It recovers 8N1 frames (optionally 8E1) from the asynchronous `rx_i` line using a ×16 sample tick derived from the system clock. It presents each byte as a one-cycle `rx_valid_o` pulse in the `clk` domain. It is the receiving end of the link whose transmit side runs from the divided clock.

---
 rtl/uart_rx.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampling (x16) UART receiver, 8N1 by default, 8E1 with
// the UART_RX_PARITY_EN macro defined.
//
// Parameters:
//   CLOCK_SYS  system clock frequency in Hz
//   BAUD       line rate in bit/s
// Ports:
//   clk              system clock
//   reset            synchronous, active-high reset
//   rx_i             asynchronous serial line, idle high
//   rx_data_o [7:0]  last good byte (LSB first on the wire), held between frames
//   rx_valid_o       1-cycle pulse, rx_data_o updated
//   rx_frame_err_o   1-cycle pulse, stop bit sampled low
//   rx_parity_err_o  1-cycle pulse, even parity mismatch (0 without the macro)
//   rx_busy_o        high whenever the receiver is not idle
// Optional feature macro: UART_RX_PARITY_EN (adds an even parity bit).

module uart_rx #(
   parameter real CLOCK_SYS = 100e6,
   parameter real BAUD      = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_frame_err_o,
   output logic       rx_parity_err_o,
   output logic       rx_busy_o
);

   localparam int TICK_DIV = $rtoi(CLOCK_SYS / (BAUD * 16.0));
   localparam int TW       = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);

   if (TICK_DIV < 2) begin : g_div_check
      $error("uart_rx: CLOCK_SYS/(BAUD*16) must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      rx_sync_q, rx_sync_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [3:0]      samp_q, samp_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            rx_s;
   logic            tick;
   logic            mid_smp;
   logic            bit_smp;
   logic            stop_smp;
   logic            par_ok;
`ifdef UART_RX_PARITY_EN
   logic            par_q, par_d;
   logic            perr_q, perr_d;
`endif

   assign rx_s    = rx_sync_q[1];
   assign tick    = (tick_cnt_q == TW'(TICK_DIV - 1));
   // Half a bit into the start bit, and one full bit after every later sample.
   assign mid_smp = tick && (samp_q == 4'd7);
   assign bit_smp = tick && (samp_q == 4'd15);
   assign stop_smp = (state_q == S_STOP) && bit_smp;

`ifdef UART_RX_PARITY_EN
   assign par_ok = ~(^shift_q ^ par_q);
`else
   assign par_ok = 1'b1;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!rx_s) state_d = S_START;
         // A high line at mid start bit is a glitch, not a frame.
         S_START: if (mid_smp) state_d = rx_s ? S_IDLE : S_DATA;
         S_DATA: begin
            if (bit_smp && (bit_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: if (bit_smp) state_d = S_STOP;
`endif
         // Leaving at mid stop bit lets a back-to-back start edge be caught.
         S_STOP:  if (bit_smp) state_d = rx_s ? S_IDLE : S_BREAK;
         // A held-low line reports once, then waits for the line to recover.
         S_BREAK: if (rx_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      rx_sync_d = {rx_sync_q[0], rx_i};

      tick_cnt_d = (state_q == S_IDLE || tick) ? '0 : tick_cnt_q + TW'(1);

      samp_d = samp_q;
      if (state_q == S_IDLE) begin
         samp_d = '0;
      end else if ((state_q == S_START) && mid_smp) begin
         samp_d = '0;
      end else if (tick) begin
         samp_d = samp_q + 4'd1;
      end

      bit_d = bit_q;
      if (state_q == S_START) begin
         bit_d = '0;
      end else if ((state_q == S_DATA) && bit_smp) begin
         bit_d = bit_q + 3'd1;
      end

      shift_d = shift_q;
      if ((state_q == S_DATA) && bit_smp) begin
         shift_d = {rx_s, shift_q[7:1]};
      end

`ifdef UART_RX_PARITY_EN
      par_d = par_q;
      if ((state_q == S_PARITY) && bit_smp) begin
         par_d = rx_s;
      end
      // Frame error takes priority over parity error.
      perr_d = stop_smp && rx_s && !par_ok;
`endif

      valid_d = stop_smp && rx_s && par_ok;
      ferr_d  = stop_smp && !rx_s;
      data_d  = valid_d ? shift_q : data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_sync_q  <= 2'b11;
         tick_cnt_q <= '0;
         samp_q     <= '0;
         bit_q      <= '0;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q     <= 1'b0;
`endif
      end else begin
         rx_sync_q  <= rx_sync_d;
         tick_cnt_q <= tick_cnt_d;
         samp_q     <= samp_d;
         bit_q      <= bit_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
         perr_q     <= perr_d;
`endif
      end
   end

   // Data-only registers: their contents are ignored until a frame fills them.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign rx_data_o      = data_q;
   assign rx_valid_o     = valid_q;
   assign rx_frame_err_o = ferr_q;
   assign rx_busy_o      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err_o = perr_q;
`else
   assign rx_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at CLOCK_SYS=1.6 MHz,
// BAUD=10 kbit/s (10 clocks per sample tick, 160 clocks per bit).
// Frames are driven from a table and by a few hand-written sequences; every
// expected result pulse is queued when its frame is driven and compared when
// the receiver produces a pulse.

module tb_uart_rx;

   localparam int T   = 10;
   localparam int BIT = 16 * T;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // Stop sample is 8 ticks into the start bit plus one bit per later bit.
   localparam int STOP_TICKS = 8 + 16 * (NBITS - 1);
   // Fall of rx_i -> D is 2 cycles; pulse registered 1 cycle after the sample.
   localparam int RES_OFS = 2 + STOP_TICKS * T + 1;

   localparam logic [2:0] K_VALID = 3'b100;
   localparam logic [2:0] K_FERR  = 3'b010;
   localparam logic [2:0] K_PERR  = 3'b001;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par_flip;
      logic       stop_b;
      int         gap;
      logic [2:0] kind;
   } vec_t;

   logic       clk;
   logic       reset;
   logic       rx_i;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_frame_err_o;
   logic       rx_parity_err_o;
   logic       rx_busy_o;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   uart_rx #(
      .CLOCK_SYS(1.6e6),
      .BAUD     (1.0e4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .rx_i           (rx_i),
      .rx_data_o      (rx_data_o),
      .rx_valid_o     (rx_valid_o),
      .rx_frame_err_o (rx_frame_err_o),
      .rx_parity_err_o(rx_parity_err_o),
      .rx_busy_o      (rx_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Scoreboard side: every result pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rx_valid_o || rx_frame_err_o || rx_parity_err_o) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", 32'({rx_valid_o, rx_frame_err_o, rx_parity_err_o}), 32'(0));
         end else begin
            mon_e = sb_q.pop_front();
            check("pulse_kind", 32'({rx_valid_o, rx_frame_err_o, rx_parity_err_o}), 32'(mon_e.kind));
            check("pulse_data", 32'(rx_data_o), 32'(mon_e.data));
            check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   // Wait until the negedge of cycle n (returns at once if already there).
   task automatic at_cycle(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Drive one frame starting now; stops early after 'limit' cycles.
   task automatic drive_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                              input int limit, input int gap);
      logic bits [NBITS];
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = d[k];
`ifdef UART_RX_PARITY_EN
      bits[9] = (^d) ^ par_flip;
`endif
      bits[NBITS-1] = stop_b;
      for (int i = 0; i < NBITS * BIT && i < limit; i++) begin
         rx_i = bits[i / BIT];
         @(posedge clk); #1;
      end
      rx_i = 1'b1;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vec_t       tbl[$];
      logic [7:0] last_good;
      int         c0;
      int         bad;
      int         w;

      tbl.push_back('{8'hA5, 1'b0, 1'b1, 50, K_VALID});
      tbl.push_back('{8'h00, 1'b0, 1'b1,  0, K_VALID});
      tbl.push_back('{8'hFF, 1'b0, 1'b1,  0, K_VALID});
      tbl.push_back('{8'h3C, 1'b0, 1'b1, 30, K_VALID});
      tbl.push_back('{8'h6E, 1'b0, 1'b0, 20, K_FERR});
      tbl.push_back('{8'h81, 1'b0, 1'b1, 10, K_VALID});
`ifdef UART_RX_PARITY_EN
      tbl.push_back('{8'h07, 1'b1, 1'b1, 10, K_PERR});
      tbl.push_back('{8'h07, 1'b0, 1'b1, 10, K_VALID});
      tbl.push_back('{8'hC3, 1'b1, 1'b0, 20, K_FERR});
`endif
      last_good = 8'h00;

      // Reset and idle
      reset = 1'b1;
      rx_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_data", 32'(rx_data_o), 32'(8'h00));
      check("reset_valid", 32'(rx_valid_o), 32'(0));
      check("reset_ferr", 32'(rx_frame_err_o), 32'(0));
      check("reset_perr", 32'(rx_parity_err_o), 32'(0));
      check("reset_busy", 32'(rx_busy_o), 32'(0));
      bad = 0;
      repeat (2000) begin
         @(negedge clk);
         if (rx_busy_o || rx_valid_o || rx_frame_err_o || rx_parity_err_o) bad++;
      end
      check("idle_quiet", 32'(bad), 32'(0));
      @(posedge clk); #1;

      // Table-driven frames
      for (int i = 0; i < tbl.size(); i++) begin
         c0 = cyc;
         if (tbl[i].kind == K_VALID) last_good = tbl[i].data;
         sb_q.push_back('{tbl[i].kind, last_good, c0 + RES_OFS});
         drive_frame(tbl[i].data, tbl[i].par_flip, tbl[i].stop_b, NBITS * BIT, tbl[i].gap);
      end

      // Glitch: 50-cycle low pulse is rejected at the mid start-bit check
      repeat (20) begin
         @(posedge clk); #1;
      end
      c0 = cyc;
      rx_i = 1'b0;
      at_cycle(c0 + 2);
      check("glitch_busy_at_d", 32'(rx_busy_o), 32'(0));
      at_cycle(c0 + 3);
      check("glitch_busy_rise", 32'(rx_busy_o), 32'(1));
      at_cycle(c0 + 50);
      rx_i = 1'b1;
      at_cycle(c0 + 82);
      check("glitch_busy_at_check", 32'(rx_busy_o), 32'(1));
      at_cycle(c0 + 83);
      check("glitch_idle_d81", 32'(rx_busy_o), 32'(0));
      @(posedge clk); #1;
      repeat (20) begin
         @(posedge clk); #1;
      end

      // Break: line held low for 3000 cycles gives one frame error only
      c0 = cyc;
      sb_q.push_back('{K_FERR, last_good, c0 + RES_OFS});
      rx_i = 1'b0;
      repeat (3000) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
      end
      check("break_busy_after", 32'(rx_busy_o), 32'(0));
      check("break_data_kept", 32'(rx_data_o), 32'(last_good));

      // Reset at D+700 of 0x5A, then a clean 0x81
      check("sb_empty_before_reset", 32'(sb_q.size()), 32'(0));
      c0 = cyc;
      drive_frame(8'h5A, 1'b0, 1'b1, 702, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      last_good = 8'h00;
      check("abort_busy", 32'(rx_busy_o), 32'(0));
      check("abort_data", 32'(rx_data_o), 32'(8'h00));
      repeat (200) begin
         @(posedge clk); #1;
      end
      c0 = cyc;
      last_good = 8'h81;
      sb_q.push_back('{K_VALID, last_good, c0 + RES_OFS});
      drive_frame(8'h81, 1'b0, 1'b1, NBITS * BIT, 20);

      // Drain the scoreboard within a bounded number of cycles
      w = 0;
      while (sb_q.size() != 0 && w < 4000) begin
         @(posedge clk);
         w++;
      end
      check("sb_drained", 32'(sb_q.size()), 32'(0));
      repeat (10) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
